// File: rtl/sync_down_counter_if.sv
// rtl/sync_down_counter_if.sv - control and status bundle for sync_down_counter
interface sync_down_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             zero;
  logic             tc;
  logic             busy;

  modport master (
    output en, load, load_val, auto_reload,
    input  q, zero, tc, busy
  );

  modport slave (
    input  en, load, load_val, auto_reload,
    output q, zero, tc, busy
  );
endinterface

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable synchronous down counter/timer, one-shot or auto-reload
// Optional prescaler (DIV clk cycles per tick) is built when DOWN_CNT_PRESCALE_EN is defined.
module sync_down_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic               clk,
  input  logic               reset,
  sync_down_counter_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rld;
  logic             tc_r;
  logic             run_en;
  logic             tick;

  if (DIV < 2 || DIV > 65536) begin : g_bad_div
    $error("sync_down_counter: DIV must be in 2..65536");
  end

  assign run_en = bus.en && (state == ST_RUN);

`ifdef DOWN_CNT_PRESCALE_EN
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  assign tick = run_en && (pre == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (bus.load) begin
      pre <= '0;
    end else if (run_en) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
    end
  end
`else
  assign tick = run_en;
`endif

  // Load wins over any coincident tick; q saturates at 0, never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      q_r   <= '0;
      rld   <= '0;
      tc_r  <= 1'b0;
    end else begin
      tc_r <= 1'b0;
      if (bus.load) begin
        q_r   <= bus.load_val;
        rld   <= bus.load_val;
        state <= (bus.load_val != '0) ? ST_RUN : ST_DONE;
      end else if (tick) begin
        if (q_r > WIDTH'(1)) begin
          q_r <= q_r - WIDTH'(1);
        end else if (q_r == WIDTH'(1)) begin
          q_r  <= '0;
          tc_r <= 1'b1;
          if (!bus.auto_reload) begin
            state <= ST_DONE;
          end
        end else if (bus.auto_reload) begin
          q_r <= rld;
        end else begin
          state <= ST_DONE;
        end
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.zero = (q_r == '0);
  assign bus.tc   = tc_r;
  assign bus.busy = (state == ST_RUN);
endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - directed and randomized checks of sync_down_counter against a behavioural model
module tb_sync_down_counter;
  localparam int WIDTH  = 4;
  localparam int DIV    = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk = 1'b0;
  logic reset;

  sync_down_counter_if #(.WIDTH(WIDTH)) bus();

  sync_down_counter #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int m_q;
  int m_rld;
  int m_st;
  int m_pre;
  int m_tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q = 0; m_rld = 0; m_st = M_IDLE; m_pre = 0; m_tc = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q"},    32'(bus.q),    32'(m_q));
    check({tag, ".tc"},   32'(bus.tc),   32'(m_tc));
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_st == M_RUN));
    check({tag, ".zero"}, 32'(bus.zero), 32'(m_q == 0));
  endtask

  task automatic drive(input bit e, input bit ld, input int lv, input bit ar);
    bus.en = e; bus.load = ld; bus.load_val = WIDTH'(lv); bus.auto_reload = ar;
  endtask

  // One clock: advance the model from the inputs the DUT sees, then compare after the edge.
  task automatic step(input string tag);
    bit fire;
    @(posedge clk);
    if (bus.load) begin
      m_q   = int'(bus.load_val);
      m_rld = m_q;
      m_pre = 0;
      m_tc  = 0;
      m_st  = (m_q != 0) ? M_RUN : M_DONE;
    end else begin
      m_tc = 0;
      if (bus.en && m_st == M_RUN) begin
`ifdef DOWN_CNT_PRESCALE_EN
        fire  = (m_pre == DIV - 1);
        m_pre = (m_pre + 1) % DIV;
`else
        fire = 1'b1;
`endif
        if (fire) begin
          if (m_q >= 2) begin
            m_q = m_q - 1;
          end else if (m_q == 1) begin
            m_q  = 0;
            m_tc = 1;
            if (!bus.auto_reload) m_st = M_DONE;
          end else if (bus.auto_reload) begin
            m_q = m_rld;
          end else begin
            m_st = M_DONE;
          end
        end
      end
    end
    #1;
    compare_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check({tag, ".rst_q"},    32'(bus.q),    32'd0);
    check({tag, ".rst_tc"},   32'(bus.tc),   32'd0);
    check({tag, ".rst_busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".rst_zero"}, 32'(bus.zero), 32'd1);
    model_clear();
    #1;
    reset = 1'b1;
  endtask

  int  tc_seen;
  bit  reached;
  bit  ar_r;

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0);
    model_clear();
    #3;
    check("reset.q",    32'(bus.q),    32'd0);
    check("reset.tc",   32'(bus.tc),   32'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.zero", 32'(bus.zero), 32'd1);
    #1;
    reset = 1'b1;
    drive(1, 0, 0, 0);
    repeat (3) step("idle");

    // one-shot from 3
    drive(1, 1, 3, 0);
    step("t1_load");
    bus.load = 1'b0;
    repeat (14) step("t1_run");

    // periodic from 2
    drive(1, 1, 2, 1);
    step("t2_load");
    bus.load = 1'b0;
    tc_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step("t2_run");
      if (bus.tc === 1'b1) tc_seen++;
    end
`ifndef DOWN_CNT_PRESCALE_EN
    check("t2_tc_count", 32'(tc_seen), 32'd4);
`endif

    // en gap mid-count
    drive(1, 1, 2, 0);
    step("t3_load");
    bus.load = 1'b0;
    repeat (3) step("t3_run");
    bus.en = 1'b0;
    repeat (5) step("t3_hold");
    bus.en = 1'b1;
    repeat (12) step("t3_resume");

    // reload at q=5 aborts the count
    drive(1, 1, 9, 0);
    step("t4_load");
    bus.load = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (m_q == 5) reached = 1'b1;
      else step("t4_run");
    end
    check("t4_reach_q5", 32'(reached), 32'd1);
    drive(1, 1, 7, 0);
    step("t4_reload");
    bus.load = 1'b0;
    repeat (40) step("t4_after");

    // zero load in both modes
    drive(1, 1, 0, 0);
    step("t5_os");
    bus.load = 1'b0;
    repeat (3) step("t5_os_hold");
    drive(1, 1, 0, 1);
    step("t5_ar");
    bus.load = 1'b0;
    repeat (3) step("t5_ar_hold");

    // async reset at q=4
    drive(1, 1, 8, 1);
    step("t6_load");
    bus.load = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (m_q == 4) reached = 1'b1;
      else step("t6_run");
    end
    check("t6_reach_q4", 32'(reached), 32'd1);
    async_reset("t6");
    repeat (5) step("t6_idle");

    // randomized traffic
    ar_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) ar_r = ~ar_r;
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
            int'($urandom_range(0, (1 << WIDTH) - 1)), ar_r);
      if ($urandom_range(0, 99) == 0) async_reset("rnd");
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
